alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 141 ++++++++++++++
 tb/tb_alu_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides, status flags,
// a running accumulator and a completed-transfer counter.
module alu_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           sel,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 zero,
    output logic                 ovf,
    output logic [COUNT_W-1:0]   op_count
);

    localparam int RES_W = 2 * WIDTH;
    localparam int SH_W  = $clog2(RES_W);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_ACC = 3'b111;

    logic               s1_valid_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         sel_q;

    logic               out_valid_q;
    logic [RES_W-1:0]   result_q;
    logic               carry_q;
    logic               zero_q;
    logic               ovf_q;
    logic [RES_W-1:0]   acc_q;
    logic [COUNT_W-1:0] op_count_q;

    logic               en1;
    logic               en2;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [RES_W-1:0]   acc_d;
    logic [RES_W-1:0]   result_d;
    logic               carry_d;
    logic               zero_d;
    logic               ovf_d;

    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign op_count  = op_count_q;

    always_comb begin
        sum_w    = {1'b0, a_q} + {1'b0, b_q};
        diff_w   = {1'b0, a_q} - {1'b0, b_q};
        // A clear on the same edge as an ACC entering S2 wins first, so the op sees acc = 0.
        acc_d    = (acc_clr ? '0 : acc_q) + RES_W'(a_q);
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (sel_q)
            OP_ADD: begin
                result_d = RES_W'(sum_w);
                carry_d  = sum_w[WIDTH];
                ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                result_d = RES_W'(diff_w[WIDTH-1:0]);
                carry_d  = diff_w[WIDTH];
                ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_MUL:  result_d = RES_W'(a_q) * RES_W'(b_q);
            OP_AND:  result_d = RES_W'(a_q & b_q);
            OP_OR:   result_d = RES_W'(a_q | b_q);
            OP_XOR:  result_d = RES_W'(a_q ^ b_q);
            OP_SHL:  result_d = RES_W'(a_q) << b_q[SH_W-1:0];
            default: result_d = acc_d;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
            op_count_q  <= '0;
        end else begin
            if (en1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    a_q   <= A;
                    b_q   <= B;
                    sel_q <= sel;
                end
            end
            if (en2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q <= result_d;
                    carry_q  <= carry_d;
                    zero_q   <= zero_d;
                    ovf_q    <= ovf_d;
                end
            end
            if (en2 && s1_valid_q && (sel_q == OP_ACC)) begin
                acc_q <= acc_d;
            end else if (acc_clr) begin
                acc_q <= '0;
            end
            if (out_valid_q && out_ready) begin
                op_count_q <= op_count_q + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): opcodes, flags, accumulator, backpressure, reset.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  sel;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic        ovf;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    alu_pipe #(.WIDTH(8), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sel(sel), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .carry(carry), .zero(zero),
        .ovf(ovf), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input logic clr2, input logic [15:0] er,
                         input logic ec, input logic ez, input logic eo);
        int k;
        @(negedge clk);
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; A = a; B = b; sel = s;
        @(negedge clk);
        in_valid = 1'b0;
        acc_clr  = clr2;
        k = 0;
        while (!out_valid && k < 6) begin
            @(negedge clk);
            acc_clr = 1'b0;
            k++;
        end
        acc_clr = 1'b0;
        if (!out_valid) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, "_res"}, 32'(result), 32'(er));
            check_eq({tag, "_flags"}, {29'd0, carry, zero, ovf}, {29'd0, ec, ez, eo});
            @(negedge clk);
            exp_cnt++;
            check_eq({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        took;
        int          idx;
        logic [15:0] exp_q [3];
        exp_q = '{16'd3, 16'd7, 16'd11};

        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; sel = '0;
        acc_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_ovalid", 32'(out_valid), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_flags", {29'd0, carry, zero, ovf}, 32'd0);
        check_eq("rst_cnt", 32'(op_count), 32'd0);
        check_eq("rst_rdy", 32'(in_ready), 32'd1);

        do_op("add",    8'd200, 8'd100, 3'b000, 1'b0, 16'h012C, 1'b1, 1'b0, 1'b0);
        do_op("sub_bw", 8'd5,   8'd7,   3'b001, 1'b0, 16'h00FE, 1'b1, 1'b0, 1'b0);
        do_op("sub_ov", 8'h80,  8'h01,  3'b001, 1'b0, 16'h007F, 1'b0, 1'b0, 1'b1);
        do_op("sub_z",  8'd9,   8'd9,   3'b001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        do_op("add_ov", 8'h7F,  8'h01,  3'b000, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b1);
        do_op("mul",    8'd255, 8'd255, 3'b010, 1'b0, 16'hFE01, 1'b0, 1'b0, 1'b0);
        do_op("and",    8'hF0,  8'h3C,  3'b011, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
        do_op("or",     8'hF0,  8'h3C,  3'b100, 1'b0, 16'h00FC, 1'b0, 1'b0, 1'b0);
        do_op("xor",    8'hF0,  8'h3C,  3'b101, 1'b0, 16'h00CC, 1'b0, 1'b0, 1'b0);
        do_op("shl9",   8'h81,  8'd9,   3'b110, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0);
        do_op("shl3",   8'h81,  8'h13,  3'b110, 1'b0, 16'h0408, 1'b0, 1'b0, 1'b0);

        do_op("acc3",   8'd3,   8'd0,   3'b111, 1'b0, 16'd3,    1'b0, 1'b0, 1'b0);
        @(negedge clk); acc_clr = 1'b1;
        @(negedge clk); acc_clr = 1'b0;
        do_op("acc10",  8'd10,  8'd0,   3'b111, 1'b0, 16'd10,   1'b0, 1'b0, 1'b0);
        do_op("acc20",  8'd20,  8'd0,   3'b111, 1'b0, 16'd30,   1'b0, 1'b0, 1'b0);
        do_op("acc_clr5", 8'd5, 8'd0,   3'b111, 1'b1, 16'd5,    1'b0, 1'b0, 1'b0);
        do_op("acc1",   8'd1,   8'd0,   3'b111, 1'b0, 16'd6,    1'b0, 1'b0, 1'b0);

        // Backpressure: two accepted, third held off until the output drains.
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("stall_rdy1", 32'(in_ready), 32'd1);
        in_valid = 1'b1; A = 8'd1; B = 8'd2; sel = 3'b000;
        @(negedge clk);
        check_eq("stall_rdy2", 32'(in_ready), 32'd1);
        A = 8'd3; B = 8'd4; sel = 3'b000;
        @(negedge clk);
        A = 8'h0F; B = 8'h04; sel = 3'b101;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("stall_rdy0", 32'(in_ready), 32'd0);
            check_eq("stall_ovalid", 32'(out_valid), 32'd1);
            check_eq("stall_hold", 32'(result), 32'd3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        idx = 0;
        for (int k = 0; k < 10 && idx < 3; k++) begin
            took = in_valid && in_ready;
            if (out_valid) begin
                check_eq("drain", 32'(result), 32'(exp_q[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
            if (took) in_valid = 1'b0;
            @(negedge clk);
        end
        check_eq("drain_n", 32'(idx), 32'd3);
        exp_cnt += 3;
        check_eq("drain_cnt", 32'(op_count), 32'(exp_cnt));
        @(negedge clk);
        check_eq("drain_empty", 32'(out_valid), 32'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; A = 8'd200; B = 8'd100; sel = 3'b000;
        @(negedge clk);
        A = 8'd9; B = 8'd1; sel = 3'b001;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("pre_rst_ovalid", 32'(out_valid), 32'd1);
        check_eq("pre_rst_carry", 32'(carry), 32'd1);
        reset = 1'b1;
        #2;
        check_eq("async_rst", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst2_ovalid", 32'(out_valid), 32'd0);
        check_eq("rst2_result", 32'(result), 32'd0);
        check_eq("rst2_flags", {29'd0, carry, zero, ovf}, 32'd0);
        check_eq("rst2_cnt", 32'(op_count), 32'd0);
        check_eq("rst2_rdy", 32'(in_ready), 32'd1);
        exp_cnt = 0;
        out_ready = 1'b1;
        do_op("post_rst_acc", 8'd7, 8'd0, 3'b111, 1'b0, 16'd7, 1'b0, 1'b0, 1'b0);
        do_op("post_rst_add", 8'd200, 8'd100, 3'b000, 1'b0, 16'h012C, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
